// File: rtl/mips_pkg.sv
// Shared definitions for the register-file write-port arbitration slice.
package mips_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PEND  = 2'd1,
        FORCE = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     data;
    } pend_entry_t;

endpackage

// File: rtl/wb_port_arbiter_fifo.sv
// Pending buffer for MDU results waiting on the register-file write port.
// Exposes its next-cycle contents so the owner can register a pending mask.
module wb_pend_fifo
    import mips_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  push,
    input  pend_entry_t                           push_entry,
    input  logic                                  pop,
    output logic                                  full,
    output logic                                  empty,
    output pend_entry_t                           head,
    output logic [DEPTH-1:0]                      valid_nxt,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0]      rd_nxt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    pend_entry_t [DEPTH-1:0] mem_q, mem_d;
    logic [DEPTH-1:0]        valid_q, valid_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        mem_d    = mem_q;
        valid_d  = valid_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_pop) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + 1'b1;
        end
        if (do_push) begin
            mem_d[wr_ptr_q]   = push_entry;
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = wr_ptr_q + 1'b1;
        end
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_comb begin
        valid_nxt = valid_d;
        for (int i = 0; i < DEPTH; i++) begin
            rd_nxt[i] = mem_d[i].rd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '0;
            valid_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            valid_q  <= valid_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between write-back and the MDU,
// buffering MDU results and forcing a one-cycle stall when they starve.
module wb_port_arbiter
    import mips_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wb_RegWrite,
    input  logic [REG_ADDR_W-1:0] wb_RegDest,
    input  logic [DATA_W-1:0]     wb_WriteReg,
    input  logic                  md_valid,
    input  logic [REG_ADDR_W-1:0] md_rd,
    input  logic [DATA_W-1:0]     md_data,
    output logic                  md_ready,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]     rf_wdata,
    output logic                  pipe_stall,
    output logic [31:0]           pending_mask
);

    localparam int SC_W = $clog2(STARVE_MAX + 1);

    arb_state_t             state_q, state_d;
    logic [SC_W-1:0]        starve_q, starve_d;
    logic [31:0]            pending_mask_q, pending_mask_d;

    logic                   fifo_full, fifo_empty, fifo_push, fifo_pop;
    pend_entry_t            fifo_head;
    logic [DEPTH-1:0]       fifo_valid_nxt;
    logic [DEPTH-1:0][REG_ADDR_W-1:0] fifo_rd_nxt;

    logic                   sel_we, wb_grant, bypass;
    logic [REG_ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]      sel_data;

    wb_pend_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (fifo_push),
        .push_entry ('{rd: md_rd, data: md_data}),
        .pop        (fifo_pop),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .head       (fifo_head),
        .valid_nxt  (fifo_valid_nxt),
        .rd_nxt     (fifo_rd_nxt)
    );

    always_comb begin
        sel_we   = 1'b0;
        sel_addr = '0;
        sel_data = '0;
        fifo_pop = 1'b0;
        wb_grant = 1'b0;
        bypass   = 1'b0;
        if (state_q == FORCE) begin
            sel_we   = !fifo_empty;
            sel_addr = fifo_head.rd;
            sel_data = fifo_head.data;
            fifo_pop = !fifo_empty;
        end else if (wb_RegWrite) begin
            sel_we   = 1'b1;
            sel_addr = wb_RegDest;
            sel_data = wb_WriteReg;
            wb_grant = 1'b1;
        end else if (!fifo_empty) begin
            sel_we   = 1'b1;
            sel_addr = fifo_head.rd;
            sel_data = fifo_head.data;
            fifo_pop = 1'b1;
        end else if (md_valid) begin
            sel_we   = 1'b1;
            sel_addr = md_rd;
            sel_data = md_data;
            bypass   = 1'b1;
        end
    end

    assign md_ready  = !fifo_full;
    assign fifo_push = md_valid && md_ready && !bypass;

    // Outputs collapse to idle values the moment reset asserts, even with live inputs.
    assign rf_we        = rst_n && sel_we && (sel_addr != '0);
    assign rf_waddr     = rst_n ? sel_addr : '0;
    assign rf_wdata     = rst_n ? sel_data : '0;
    assign pipe_stall   = (state_q == FORCE);
    assign pending_mask = pending_mask_q;

    always_comb begin
        starve_d = starve_q;
        if (fifo_pop) begin
            starve_d = '0;
        end else if (wb_grant && !fifo_empty && starve_q != SC_W'(STARVE_MAX)) begin
            starve_d = starve_q + 1'b1;
        end

        state_d = (|fifo_valid_nxt) ? PEND : IDLE;
        if (state_q != FORCE && starve_d == SC_W'(STARVE_MAX)) begin
            state_d = FORCE;
        end
    end

    always_comb begin
        pending_mask_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (fifo_valid_nxt[i] && fifo_rd_nxt[i] != '0) begin
                pending_mask_d[fifo_rd_nxt[i]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            starve_q       <= '0;
            pending_mask_q <= '0;
        end else begin
            state_q        <= state_d;
            starve_q       <= starve_d;
            pending_mask_q <= pending_mask_d;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Randomized scoreboard bench for wb_port_arbiter against a queue-based
// reference model of the write-port sharing rules.
module tb_wb_port_arbiter;
  import mips_pkg::*;

  localparam int DEPTH      = 2;
  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_RegWrite = 1'b0;
  logic [4:0]  wb_RegDest = '0;
  logic [31:0] wb_WriteReg = '0;
  logic        md_valid = 1'b0;
  logic [4:0]  md_rd = '0;
  logic [31:0] md_data = '0;
  logic        md_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        pipe_stall;
  logic [31:0] pending_mask;

  wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wb_RegWrite  (wb_RegWrite),
    .wb_RegDest   (wb_RegDest),
    .wb_WriteReg  (wb_WriteReg),
    .md_valid     (md_valid),
    .md_rd        (md_rd),
    .md_data      (md_data),
    .md_ready     (md_ready),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .pipe_stall   (pipe_stall),
    .pending_mask (pending_mask)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard state
  logic [36:0] exp_q[$];
  int total = 0;
  int bad = 0;

  // reference model: pending results in arrival order, starvation tally
  logic [36:0] pend_m[$];
  int starve_m = 0;
  bit force_m = 1'b0;
  bit wb_hold = 1'b0;
  bit md_hold = 1'b0;
  int md_seq = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, want, $time);
    end
  endtask

  // monitor: every register-file write must match the next expected write
  always @(negedge clk) begin
    logic [36:0] e;
    if (rst_n && rf_we) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write got=r%0d:%h expected=none at %0t", rf_waddr, rf_wdata, $time);
      end else begin
        e = exp_q.pop_front();
        if ({rf_waddr, rf_wdata} !== e) begin
          bad++;
          $display("FAIL write got=r%0d:%h expected=r%0d:%h at %0t",
                   rf_waddr, rf_wdata, e[36:32], e[31:0], $time);
        end
      end
    end
  end

  function automatic logic [4:0] rand_wb_rd();
    int v;
    v = $urandom_range(0, 12);
    return (v < 5) ? 5'(v) : 5'(v + 3);
  endfunction

  function automatic logic [4:0] rand_md_rd();
    int v;
    v = $urandom_range(0, 16);
    return (v == 16) ? 5'd0 : 5'(16 + v);
  endfunction

  // driver: one clock cycle of stimulus plus the model's view of that cycle
  task automatic step(input bit want_wb, input logic [4:0] wrd, input logic [31:0] wdat,
                      input bit want_md, input logic [4:0] mrd, input logic [31:0] mdat);
    logic [31:0] mask_m;
    logic [36:0] head;
    bit do_pop, bypass, ready_m, accepted;
    @(posedge clk);
    #1;
    if (!wb_hold) begin
      wb_RegWrite = want_wb; wb_RegDest = wrd; wb_WriteReg = wdat;
    end
    if (!md_hold) begin
      md_valid = want_md; md_rd = mrd; md_data = mdat;
    end
    mask_m = '0;
    foreach (pend_m[i]) if (pend_m[i][36:32] != 0) mask_m[pend_m[i][36:32]] = 1'b1;
    ready_m = (pend_m.size() < DEPTH);
    do_pop = 1'b0;
    bypass = 1'b0;
    if (force_m && pend_m.size() > 0) begin
      do_pop = 1'b1;
    end else if (wb_RegWrite) begin
      if (wb_RegDest != 0) exp_q.push_back({wb_RegDest, wb_WriteReg});
      if (pend_m.size() > 0) starve_m++;
    end else if (pend_m.size() > 0) begin
      do_pop = 1'b1;
    end else if (md_valid) begin
      bypass = 1'b1;
      if (md_rd != 0) exp_q.push_back({md_rd, md_data});
    end
    if (do_pop) begin
      head = pend_m[0];
      if (head[36:32] != 0) exp_q.push_back(head);
    end
    accepted = md_valid && ready_m;
    @(negedge clk);
    check("md_ready", 32'(md_ready), 32'(ready_m));
    check("pipe_stall", 32'(pipe_stall), 32'(force_m));
    check("pending_mask", pending_mask, mask_m);
    if (wb_RegWrite) check("waw_hazard", 32'(pending_mask[wb_RegDest]), 32'd0);
    if (do_pop) begin
      void'(pend_m.pop_front());
      starve_m = 0;
    end
    if (accepted && !bypass) pend_m.push_back({md_rd, md_data});
    if (accepted) md_seq++;
    wb_hold = force_m && wb_RegWrite;
    md_hold = md_valid && !accepted;
    force_m = (starve_m == STARVE_MAX);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic wb_only(input int n);
    for (int i = 0; i < n; i++) step(1'b1, rand_wb_rd(), $urandom, 1'b0, '0, '0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // reset values
    #12;
    check("reset_rf_we", 32'(rf_we), 32'd0);
    check("reset_rf_waddr", 32'(rf_waddr), 32'd0);
    check("reset_rf_wdata", rf_wdata, 32'd0);
    check("reset_pipe_stall", 32'(pipe_stall), 32'd0);
    check("reset_md_ready", 32'(md_ready), 32'd1);
    check("reset_pending_mask", pending_mask, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // bypass
    step(1'b0, '0, '0, 1'b1, 5'd5, 32'h1234);
    idle(2);

    // conflict: WB wins, r7 buffered then drained on the next free cycle
    step(1'b1, 5'd3, 32'hA, 1'b1, 5'd7, 32'hB);
    idle(3);

    // starvation: one buffered entry under continuous WB
    step(1'b1, 5'd3, 32'hA1, 1'b1, 5'd7, 32'hB1);
    wb_only(8);
    idle(2);

    // full buffer with MDU holding its third result
    md_seq = 0;
    for (int i = 0; i < 30 && md_seq < 3; i++)
      step(1'b1, rand_wb_rd(), $urandom, 1'b1, 5'(20 + md_seq), 32'hC000 + 32'(md_seq));
    wb_only(12);
    idle(3);

    // register 0 result is buffered, pops, never writes, never masks
    step(1'b1, 5'd2, 32'h22, 1'b1, 5'd0, 32'hDEAD);
    idle(3);

    // random traffic
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 9) < 7), rand_wb_rd(), $urandom,
           ($urandom_range(0, 9) < 4), rand_md_rd(), $urandom);
    idle(6);

    // reset in the middle of a forced drain with two entries buffered
    step(1'b1, 5'd1, 32'h11, 1'b1, 5'd24, 32'hE0);
    step(1'b1, 5'd2, 32'h12, 1'b1, 5'd25, 32'hE1);
    wb_only(3);
    check("pre_reset_force", 32'(force_m), 32'd1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midreset_rf_we", 32'(rf_we), 32'd0);
    check("midreset_rf_waddr", 32'(rf_waddr), 32'd0);
    check("midreset_rf_wdata", rf_wdata, 32'd0);
    check("midreset_pipe_stall", 32'(pipe_stall), 32'd0);
    check("midreset_md_ready", 32'(md_ready), 32'd1);
    check("midreset_pending_mask", pending_mask, 32'd0);
    wb_RegWrite = 1'b0; md_valid = 1'b0;
    pend_m.delete();
    exp_q.delete();
    starve_m = 0; force_m = 1'b0; wb_hold = 1'b0; md_hold = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(8);

    check("leftover_expected", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
